// File: rtl/sparse_block_expander_pkg.sv
// Shared definitions for the sparse block expander: FSM encoding and
// default parameter values used by the top and its prefix counter.
package sparse_block_expander_pkg;

    localparam int DEFAULT_BITMASK_LENGTH  = 16;
    localparam int DEFAULT_INDEX_BITWIDTH  = 5;
    localparam int DEFAULT_DATA_WIDTH      = 8;
    localparam int DEFAULT_VALUES_PER_BEAT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/sparse_block_expander_mask_prefix_counter.sv
// Combinational inclusive prefix popcount of a block mask; field i holds the
// number of ones in mask bits 0..i, so the top field is the block's total.
module mask_prefix_counter
    import sparse_block_expander_pkg::*;
#(
    parameter int BITMASK_LENGTH = DEFAULT_BITMASK_LENGTH,
    parameter int INDEX_BITWIDTH = DEFAULT_INDEX_BITWIDTH
) (
    input  logic [BITMASK_LENGTH-1:0]                mask,
    output logic [BITMASK_LENGTH*INDEX_BITWIDTH-1:0] prefix
);

    logic [INDEX_BITWIDTH-1:0] running;

    // NOTE: blocking assignments here build a ripple of adders; the running
    // total must be visible to the next loop iteration within the same pass.
    always_comb begin
        prefix  = '0;
        running = '0;
        for (int i = 0; i < BITMASK_LENGTH; i++) begin
            running = running + INDEX_BITWIDTH'(mask[i]);
            prefix[i*INDEX_BITWIDTH +: INDEX_BITWIDTH] = running;
        end
    end

endmodule

// File: rtl/sparse_block_expander.sv
// Expands a bitmask plus a stream of compacted values into a dense block:
// IDLE takes the mask, COLLECT gathers value beats, EMIT presents the block.
module sparse_block_expander
    import sparse_block_expander_pkg::*;
#(
    parameter int BITMASK_LENGTH  = DEFAULT_BITMASK_LENGTH,
    parameter int INDEX_BITWIDTH  = DEFAULT_INDEX_BITWIDTH,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int VALUES_PER_BEAT = DEFAULT_VALUES_PER_BEAT
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 mask_valid,
    input  logic [BITMASK_LENGTH-1:0]            mask_data,
    output logic                                 mask_ready,
    input  logic                                 value_valid,
    input  logic [VALUES_PER_BEAT*DATA_WIDTH-1:0] value_data,
    output logic                                 value_ready,
    output logic                                 dense_valid,
    output logic [BITMASK_LENGTH*DATA_WIDTH-1:0] dense_data,
    input  logic                                 dense_ready
);

    localparam int SLOT_W = $clog2(BITMASK_LENGTH);

    state_t state, state_next;

    logic [BITMASK_LENGTH-1:0]                mask_reg;
    logic [INDEX_BITWIDTH-1:0]                n_reg;
    logic [INDEX_BITWIDTH-1:0]                wp;
    logic [DATA_WIDTH-1:0]                    buffer      [BITMASK_LENGTH];
    logic [DATA_WIDTH-1:0]                    buffer_next [BITMASK_LENGTH];
    logic [BITMASK_LENGTH*DATA_WIDTH-1:0]     dense_next;

    logic [BITMASK_LENGTH-1:0]                count_mask;
    logic [BITMASK_LENGTH*INDEX_BITWIDTH-1:0] prefix;
    logic [INDEX_BITWIDTH-1:0]                popcount;

    logic mask_fire;
    logic value_fire;
    logic last_beat;

    // In IDLE the counter sizes the incoming mask; afterwards it indexes the held one.
    assign count_mask = (state == IDLE) ? mask_data : mask_reg;

    mask_prefix_counter #(
        .BITMASK_LENGTH (BITMASK_LENGTH),
        .INDEX_BITWIDTH (INDEX_BITWIDTH)
    ) u_prefix (
        .mask   (count_mask),
        .prefix (prefix)
    );

    assign popcount   = prefix[(BITMASK_LENGTH-1)*INDEX_BITWIDTH +: INDEX_BITWIDTH];
    assign mask_fire  = mask_valid & mask_ready;
    assign value_fire = value_valid & value_ready;
    assign last_beat  = (wp + INDEX_BITWIDTH'(VALUES_PER_BEAT)) >= n_reg;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: outputs and next state get defaults first so no path infers a latch.
    always_comb begin
        state_next  = state;
        mask_ready  = 1'b0;
        value_ready = 1'b0;
        dense_valid = 1'b0;
        case (state)
            IDLE: begin
                mask_ready = 1'b1;
                if (mask_valid) state_next = (popcount == '0) ? EMIT : COLLECT;
            end
            COLLECT: begin
                value_ready = 1'b1;
                if (value_valid && last_beat) state_next = EMIT;
            end
            EMIT: begin
                dense_valid = 1'b1;
                if (dense_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Buffer contents as they will be after this cycle's beat, so the final
    // beat's lanes are available to the dense register on the same edge.
    always_comb begin
        for (int i = 0; i < BITMASK_LENGTH; i++) buffer_next[i] = buffer[i];
        for (int lane = 0; lane < VALUES_PER_BEAT; lane++) begin
            if ((wp + INDEX_BITWIDTH'(lane)) < n_reg)
                buffer_next[SLOT_W'(wp + INDEX_BITWIDTH'(lane))] =
                    value_data[lane*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        dense_next = '0;
        for (int i = 0; i < BITMASK_LENGTH; i++) begin
            if (mask_reg[i])
                dense_next[i*DATA_WIDTH +: DATA_WIDTH] =
                    buffer_next[SLOT_W'(prefix[i*INDEX_BITWIDTH +: INDEX_BITWIDTH] - INDEX_BITWIDTH'(1))];
        end
    end

    // NOTE: the value buffer is deliberately not reset; every slot read for a
    // block is written by that block's beats before the dense register loads.
    always_ff @(posedge clock) begin
        if (value_fire) begin
            for (int i = 0; i < BITMASK_LENGTH; i++) buffer[i] <= buffer_next[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask_reg   <= '0;
            n_reg      <= '0;
            wp         <= '0;
            dense_data <= '0;
        end else begin
            if (mask_fire) begin
                mask_reg <= mask_data;
                n_reg    <= popcount;
                wp       <= '0;
                if (popcount == '0) dense_data <= '0;
            end
            if (value_fire) begin
                wp <= wp + INDEX_BITWIDTH'(VALUES_PER_BEAT);
                if (last_beat) dense_data <= dense_next;
            end
        end
    end

endmodule

// File: tb/tb_sparse_block_expander.sv
// Directed bench for sparse_block_expander: a queue of model-computed dense
// blocks is compared every EMIT cycle, plus literal and timing checks.
module tb_sparse_block_expander;

    logic         clock = 1'b0;
    logic         reset;
    logic         mask_valid;
    logic [15:0]  mask_data;
    logic         mask_ready;
    logic         value_valid;
    logic [31:0]  value_data;
    logic         value_ready;
    logic         dense_valid;
    logic [127:0] dense_data;
    logic         dense_ready;

    int n_pass  = 0;
    int n_total = 0;

    logic [127:0] exp_q [$];
    logic [31:0]  beats_q [$];
    logic [127:0] saved;

    always #5 clock = ~clock;

    sparse_block_expander dut (
        .clock       (clock),
        .reset       (reset),
        .mask_valid  (mask_valid),
        .mask_data   (mask_data),
        .mask_ready  (mask_ready),
        .value_valid (value_valid),
        .value_data  (value_data),
        .value_ready (value_ready),
        .dense_valid (dense_valid),
        .dense_data  (dense_data),
        .dense_ready (dense_ready)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scatter compacted values, in order, into the positions of the mask's ones.
    function automatic logic [127:0] expand(input logic [15:0] m, input logic [31:0] beats [$]);
        logic [127:0] d;
        logic [31:0]  b;
        int k;
        d = '0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                b = beats[k / 4];
                d[i*8 +: 8] = b[(k % 4)*8 +: 8];
                k++;
            end
        end
        return d;
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            check("one_hot_ready_valid", 128'($countones({mask_ready, value_ready, dense_valid})), 128'd1);
            if (dense_valid) begin
                if (exp_q.size() == 0) begin
                    check("dense_unexpected", 128'(dense_valid), 128'd0);
                end else begin
                    check("dense_model", dense_data, exp_q[0]);
                    if (dense_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_mask(input logic [15:0] m);
        int k;
        @(posedge clock); #1;
        mask_valid = 1'b1;
        mask_data  = m;
        k = 0;
        @(negedge clock);
        while (!mask_ready && k < 50) begin @(negedge clock); k++; end
        if (!mask_ready) check("mask_handshake_timeout", 128'(mask_ready), 128'd1);
        @(posedge clock); #1;
        mask_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] v);
        int k;
        @(posedge clock); #1;
        value_valid = 1'b1;
        value_data  = v;
        k = 0;
        @(negedge clock);
        while (!value_ready && k < 50) begin @(negedge clock); k++; end
        if (!value_ready) check("beat_handshake_timeout", 128'(value_ready), 128'd1);
        @(posedge clock); #1;
        value_valid = 1'b0;
    endtask

    task automatic send_beats();
        foreach (beats_q[i]) send_beat(beats_q[i]);
    endtask

    task automatic accept_dense();
        int k;
        k = 0;
        @(negedge clock);
        while (!dense_valid && k < 50) begin @(negedge clock); k++; end
        if (!dense_valid) check("dense_timeout", 128'(dense_valid), 128'd1);
        @(posedge clock); #1;
        dense_ready = 1'b1;
        @(posedge clock); #1;
        dense_ready = 1'b0;
        @(negedge clock);
        check("idle_after_handshake_mask_ready", 128'(mask_ready), 128'd1);
        check("idle_after_handshake_dense_valid", 128'(dense_valid), 128'd0);
    endtask

    initial begin
        reset       = 1'b1;
        mask_valid  = 1'b0;
        mask_data   = '0;
        value_valid = 1'b0;
        value_data  = '0;
        dense_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_mask_ready", 128'(mask_ready), 128'd1);
        check("reset_value_ready", 128'(value_ready), 128'd0);
        check("reset_dense_valid", 128'(dense_valid), 128'd0);
        check("reset_dense_data", dense_data, 128'd0);

        // Empty mask: straight to EMIT, offered value beat must not be taken.
        beats_q.delete();
        exp_q.push_back(expand(16'h0000, beats_q));
        value_valid = 1'b1;
        value_data  = 32'hCAFEF00D;
        send_mask(16'h0000);
        @(negedge clock);
        check("zero_mask_latency", 128'(dense_valid), 128'd1);
        check("zero_mask_data", dense_data, 128'd0);
        check("zero_mask_no_value_ready", 128'(value_ready), 128'd0);
        accept_dense();
        value_valid = 1'b0;

        // All-ones mask: dense is the concatenated values in order.
        beats_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        exp_q.push_back(expand(16'hFFFF, beats_q));
        send_mask(16'hFFFF);
        send_beats();
        @(negedge clock);
        check("full_mask_latency", 128'(dense_valid), 128'd1);
        check("full_mask_literal", dense_data, 128'h100F0E0D0C0B0A090807060504030201);
        accept_dense();

        // Two endpoints; a mask offered during EMIT waits for the dense handshake.
        beats_q = '{32'hDDCCBBAA};
        exp_q.push_back(expand(16'h8001, beats_q));
        send_mask(16'h8001);
        send_beats();
        @(negedge clock);
        check("ends_latency", 128'(dense_valid), 128'd1);
        check("ends_literal", dense_data, 128'hBB0000000000000000000000000000AA);
        beats_q = '{32'h44332211, 32'h88776655};
        exp_q.push_back(expand(16'h00F1, beats_q));
        @(posedge clock); #1;
        mask_valid  = 1'b1;
        mask_data   = 16'h00F1;
        dense_ready = 1'b1;
        @(posedge clock); #1;
        dense_ready = 1'b0;
        check("mask_ready_after_dense_hs", 128'(mask_ready), 128'd1);
        @(posedge clock); #1;
        mask_valid = 1'b0;
        check("mask_taken_next_cycle", 128'(value_ready), 128'd1);

        // N=5: second beat's upper three lanes are discarded.
        send_beats();
        @(negedge clock);
        check("n5_latency", 128'(dense_valid), 128'd1);
        check("n5_literal", dense_data, 128'h00000000000000005544332200000011);
        accept_dense();

        // Back-pressure: dense holds while value beats are offered and ignored.
        beats_q = '{32'h44332211, 32'h88776655};
        exp_q.push_back(expand(16'h0F0F, beats_q));
        send_mask(16'h0F0F);
        send_beats();
        @(negedge clock);
        check("stall_literal", dense_data, 128'h00000000887766550000000044332211);
        saved = dense_data;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            value_valid = ~value_valid;
            value_data  = 32'hDEADBEEF;
            @(negedge clock);
            check("stall_data_stable", dense_data, saved);
            check("stall_dense_valid", 128'(dense_valid), 128'd1);
            check("stall_mask_ready", 128'(mask_ready), 128'd0);
            check("stall_value_ready", 128'(value_ready), 128'd0);
        end
        value_valid = 1'b0;
        accept_dense();

        // Reset after the first of two beats aborts the block.
        send_mask(16'h00FF);
        send_beat(32'h04030201);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("abort_mask_ready", 128'(mask_ready), 128'd1);
        check("abort_value_ready", 128'(value_ready), 128'd0);
        check("abort_dense_valid", 128'(dense_valid), 128'd0);
        check("abort_dense_data", dense_data, 128'd0);

        beats_q = '{32'h0000BBAA};
        exp_q.push_back(expand(16'h0101, beats_q));
        send_mask(16'h0101);
        send_beats();
        @(negedge clock);
        check("post_reset_latency", 128'(dense_valid), 128'd1);
        check("post_reset_literal", dense_data, 128'h00000000000000BB00000000000000AA);
        accept_dense();

        check("all_blocks_consumed", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sparse_block_expander.md
SPARSE_BLOCK_EXPANDER -- requirements
Module: sparse_block_expander

Interface
REQ-001 Parameter BITMASK_LENGTH, default 16, dense elements per block (and mask bits).
REQ-002 Parameter INDEX_BITWIDTH, default 5, prefix-count and pointer width; SHALL be at least clog2(BITMASK_LENGTH+1).
REQ-003 Parameter DATA_WIDTH, default 8, bits per element.
REQ-004 Parameter VALUES_PER_BEAT, default 4, compacted values per input beat; SHALL divide BITMASK_LENGTH.
REQ-005 clock  input  1  sole clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mask_valid  input  1  a block bitmask is offered.
REQ-008 mask_data  input  BITMASK_LENGTH  bitmask; bit i=1 means dense element i is nonzero; LSB is element 0.
REQ-009 mask_ready  output  1  mask accepted when mask_valid and mask_ready are both high.
REQ-010 value_valid  input  1  a compacted value beat is offered.
REQ-011 value_data  input  VALUES_PER_BEAT*DATA_WIDTH  compacted values; lane 0 in the LSBs is earliest in order.
REQ-012 value_ready  output  1  beat accepted when value_valid and value_ready are both high.
REQ-013 dense_valid  output  1  dense block available.
REQ-014 dense_data  output  BITMASK_LENGTH*DATA_WIDTH  dense block; element i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-015 dense_ready  input  1  consumer accepts dense_data when dense_valid and dense_ready are both high.

Function
REQ-016 FSM states: IDLE, COLLECT, EMIT; mask_ready=1 only in IDLE, value_ready=1 only in COLLECT, dense_valid=1 only in EMIT.
REQ-017 IDLE: on mask handshake, register mask and required count N=popcount(mask); if N=0 go to EMIT, else clear write pointer and go to COLLECT.
REQ-018 COLLECT: each accepted beat writes lanes 0..VALUES_PER_BEAT-1 into value buffer slots wp..wp+VALUES_PER_BEAT-1 that are below N; wp advances by VALUES_PER_BEAT; lanes at or beyond N are discarded.
REQ-019 Beats required = ceil(N/VALUES_PER_BEAT); the beat that makes wp reach or exceed N moves the FSM to EMIT in the next cycle.
REQ-020 Entering EMIT, dense_data is registered: element i = buffer[prefix(i)-1] if mask bit i=1, else all zeros, where prefix(i) = number of ones in mask bits 0..i inclusive.
REQ-021 EMIT: dense_data and dense_valid SHALL hold stable until dense_ready; on handshake, FSM goes to IDLE the next cycle.
REQ-022 Latency: last value beat accepted at cycle t gives dense_valid at t+1; N=0 mask accepted at t gives dense_valid at t+1.
REQ-023 Throughput: a new mask is accepted no earlier than the cycle after dense handshake; no mask/value acceptance overlaps EMIT.
REQ-024 value_valid while in IDLE or EMIT is ignored (not consumed); mask_valid outside IDLE is ignored.
REQ-025 All-ones mask: N=BITMASK_LENGTH, exactly BITMASK_LENGTH/VALUES_PER_BEAT beats, dense equals concatenated values in order.
REQ-026 Prefix-count arithmetic is unsigned INDEX_BITWIDTH bits; it SHALL not overflow for legal parameters.

Reset
REQ-027 Synchronous reset: FSM to IDLE; mask_ready=1, value_ready=0, dense_valid=0 in the cycle after reset is sampled.
REQ-028 Registered mask, N, wp and dense_data are cleared to zero; value buffer need not be cleared.
REQ-029 Reset asserted mid-COLLECT or mid-EMIT aborts the block; no partial dense output is ever presented.

Structure
REQ-030 Shared package holds the FSM state encoding (IDLE=0, COLLECT=1, EMIT=2, 2 bits) and default parameter constants.
REQ-031 One sub-module, mask_prefix_counter: combinational inclusive prefix popcount of the mask, giving BITMASK_LENGTH fields of INDEX_BITWIDTH bits with the LSB field for element 0; its top field supplies N.

Verification
REQ-032 Mask 0x0000 -> dense_valid one cycle after mask handshake, all 16 elements 0x00, no value beat consumed.
REQ-033 Mask 0xFFFF, beats 0x04030201,0x08070605,0x0C0B0A09,0x100F0E0D -> dense element i = i+1.
REQ-034 Mask 0x8001, one beat 0xDDCCBBAA -> element 0=0xAA, element 15=0xBB, others 0; lanes 0xCC/0xDD discarded; next mask accepted after dense handshake.
REQ-035 Mask 0x00F1 (N=5), beats 0x44332211,0x88776655 -> elements 0,4,5,6,7 = 0x11,0x22,0x33,0x44,0x55; second beat's upper three lanes discarded.
REQ-036 dense_ready held low 10 cycles in EMIT -> dense_data stable, mask_ready and value_ready low throughout; value_valid pulses not consumed.
REQ-037 Reset asserted after first of two required beats -> next cycle IDLE, dense_valid=0; fresh block afterwards expands correctly.
